// File: rtl/tinyfpga_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : tinyfpga_cfg_loader
// Description : Bitstream loader for the tinyfpga LUT fabric. Receives framed
//               bytes (SYNC, N, N x {lo,hi}, checksum), writes N LUT4 truth
//               tables to the fabric config store in address order and enables
//               the fabric only after a checksum-valid frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tinyfpga_cfg_loader #(
  parameter int          NUM_LUTS  = 16,
  parameter int          ADDR_W    = 4,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  input  logic              wr_ready,
  output logic              fabric_en,
  output logic              cfg_err,
  output logic              busy
);

  // One spare bit so that a word count equal to 2**ADDR_W still fits.
  localparam int CNT_W = ADDR_W + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_LO    = 3'd2;
  localparam logic [2:0] S_HI    = 3'd3;
  localparam logic [2:0] S_WR    = 3'd4;
  localparam logic [2:0] S_CHK   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERROR = 3'd7;

  logic [2:0]       state;
  logic [2:0]       state_nx;
  logic [CNT_W-1:0] n_words;
  logic [CNT_W-1:0] idx;
  logic [7:0]       sum;

  logic             byte_acc;
  logic             is_sync;
  logic             hdr_bad;
  logic             last_word;
  logic [7:0]       chk_total;

  assign byte_acc  = in_valid && in_ready;
  assign is_sync   = (in_data == SYNC_BYTE);
  assign hdr_bad   = (in_data == 8'd0) || (32'(in_data) > 32'(NUM_LUTS));
  assign last_word = ((idx + CNT_W'(1)) == n_words);
  assign chk_total = sum + in_data;

  // State register; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: frame parser. Inside a frame a sync value is plain data.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (byte_acc && is_sync) state_nx = S_HDR;
      S_HDR:   if (byte_acc) state_nx = hdr_bad ? S_ERROR : S_LO;
      S_LO:    if (byte_acc) state_nx = S_HI;
      S_HI:    if (byte_acc) state_nx = S_WR;
      S_WR:    if (wr_ready) state_nx = last_word ? S_CHK : S_LO;
      S_CHK:   if (byte_acc) state_nx = (chk_total == 8'd0) ? S_DONE : S_ERROR;
      S_DONE:  if (byte_acc && is_sync) state_nx = S_HDR;
      S_ERROR: if (byte_acc && is_sync) state_nx = S_HDR;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state only, so they never glitch.
  always_comb begin
    wr_valid  = 1'b0;
    in_ready  = 1'b1;
    busy      = 1'b0;
    fabric_en = 1'b0;
    cfg_err   = 1'b0;
    case (state)
      S_HDR, S_LO, S_HI, S_CHK: busy = 1'b1;
      S_WR: begin
        busy     = 1'b1;
        wr_valid = 1'b1;
        in_ready = 1'b0;
      end
      S_DONE:  fabric_en = 1'b1;
      S_ERROR: cfg_err   = 1'b1;
      default: ;
    endcase
  end

  // Datapath: word count, running checksum, word index and write payload.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_words <= '0;
      idx     <= '0;
      sum     <= 8'd0;
      wr_addr <= '0;
      wr_data <= 16'd0;
    end else begin
      if (byte_acc) begin
        case (state)
          S_HDR: begin
            if (!hdr_bad) begin
              n_words <= CNT_W'(in_data);
              sum     <= in_data;
              idx     <= '0;
            end
          end
          S_LO: begin
            wr_data[7:0] <= in_data;
            sum          <= sum + in_data;
          end
          S_HI: begin
            wr_data[15:8] <= in_data;
            sum           <= sum + in_data;
            wr_addr       <= idx[ADDR_W-1:0];
          end
          default: ;
        endcase
      end
      if (state == S_WR && wr_ready) begin
        idx <= idx + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire
